// File: rtl/spart_pkg.sv
// Shared defaults and capture-FSM state encoding for the SPART receive path.
package spart_pkg;

   localparam int SPART_DEPTH = 8;
   localparam int SPART_AW    = 3;
   localparam int SPART_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACK      = 2'd1,
      WAIT_CLR = 2'd2
   } cap_state_t;

endpackage

// File: rtl/spart_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port; contents are not reset.
module spart_fifo_mem
   import spart_pkg::*;
#(
   parameter int DEPTH = SPART_DEPTH,
   parameter int AW    = SPART_AW,
   parameter int WIDTH = SPART_WIDTH
) (
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/spart_rx_fifo.sv
// Receive FIFO behind the SPART receiver: pops bytes via rda/rx_read, head shown fall-through.
// Latency: write edge -> dout valid next cycle; rda rise -> rx_read two cycles later.
// Backpressure: full FIFO withholds rx_read; with SPART_RX_FIFO_OVR_EN the byte is acked, dropped, overrun set.
module spart_rx_fifo
   import spart_pkg::*;
#(
   parameter int DEPTH = SPART_DEPTH,
   parameter int AW    = SPART_AW,
   parameter int WIDTH = SPART_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rda,
   input  logic [WIDTH-1:0] rx_data,
   output logic             rx_read,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count,
   output logic             overrun,
   input  logic             clr_ovr
);

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   cap_state_t       r_state;
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             r_empty;
   logic             r_full;
   logic             r_rx_read;
   logic             w_push;
   logic             w_pop;
   logic             w_drop;
   logic [AW:0]      w_count_nxt;
   logic [WIDTH-1:0] w_head;

   assign w_push = (r_state == IDLE) && rda && !r_full;
   assign w_pop  = rd_en && !r_empty;

`ifdef SPART_RX_FIFO_OVR_EN
   logic r_overrun;

   assign w_drop = (r_state == IDLE) && rda && r_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_overrun <= 1'b0;
      else if (clr_ovr) r_overrun <= 1'b0;
      else if (w_drop)  r_overrun <= 1'b1;
   end

   assign overrun = r_overrun;
`else
   logic w_unused_clr;

   assign w_drop       = 1'b0;
   assign w_unused_clr = clr_ovr;
   assign overrun      = 1'b0;
`endif

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Flags are derived from the next count so they stay in step with it every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == LP_DEPTH);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_rx_read <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_rx_read <= 1'b0;
               if (w_push || w_drop) r_state <= ACK;
            end
            ACK: begin
               r_rx_read <= 1'b1;
               r_state   <= WAIT_CLR;
            end
            WAIT_CLR: begin
               r_rx_read <= 1'b0;
               if (!rda) r_state <= IDLE;
            end
            default: begin
               r_rx_read <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   spart_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk     (clk),
      .i_wr_en (w_push),
      .i_waddr (r_wptr),
      .i_wdata (rx_data),
      .i_raddr (r_rptr),
      .o_rdata (w_head)
   );

   assign dout    = r_empty ? '0 : w_head;
   assign empty   = r_empty;
   assign full    = r_full;
   assign count   = r_count;
   assign rx_read = r_rx_read;

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Randomised bench for spart_rx_fifo against a queue-based model of the receive buffer.
module tb_spart_rx_fifo;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int WIDTH = 8;
`ifdef SPART_RX_FIFO_OVR_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             rda = 1'b0;
   logic [WIDTH-1:0] rx_data = '0;
   logic             rd_en = 1'b0;
   logic             clr_ovr = 1'b0;
   logic             rx_read;
   logic [WIDTH-1:0] dout;
   logic             empty;
   logic             full;
   logic [AW:0]      count;
   logic             overrun;

   spart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rda     (rda),
      .rx_data (rx_data),
      .rx_read (rx_read),
      .rd_en   (rd_en),
      .dout    (dout),
      .empty   (empty),
      .full    (full),
      .count   (count),
      .overrun (overrun),
      .clr_ovr (clr_ovr)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: byte queue plus the receiver handshake as seen from outside.
   logic [WIDTH-1:0] q[$];
   bit busy, take_d, ovr_m, exp_rx_read;

   task automatic model_reset();
      q.delete();
      busy        = 1'b0;
      take_d      = 1'b0;
      ovr_m       = 1'b0;
      exp_rx_read = 1'b0;
   endtask

   task automatic model_edge();
      int sz;
      bit pop, is_full, cap, drop;
      sz      = q.size();
      pop     = rd_en && (sz > 0);
      is_full = (sz == DEPTH);
      cap     = rda && !busy && !is_full;
      drop    = OVR_EN && rda && !busy && is_full;
      exp_rx_read = take_d;
      take_d      = cap || drop;
      if (busy && !rda)     busy = 1'b0;
      else if (cap || drop) busy = 1'b1;
      if (pop) void'(q.pop_front());
      if (cap) q.push_back(rx_data);
      if (clr_ovr)   ovr_m = 1'b0;
      else if (drop) ovr_m = 1'b1;
   endtask

   task automatic check_outputs();
      logic [WIDTH-1:0] exp_dout;
      exp_dout = (q.size() > 0) ? q[0] : '0;
      check("count",   32'(count),   32'(q.size()));
      check("empty",   32'(empty),   32'(q.size() == 0));
      check("full",    32'(full),    32'(q.size() == DEPTH));
      check("dout",    32'(dout),    32'(exp_dout));
      check("rx_read", 32'(rx_read), 32'(exp_rx_read));
      check("overrun", 32'(overrun), 32'(ovr_m));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   bit ackd = 1'b0;
   int gap  = 0;
   int p_push, p_pop;

   task automatic drive();
      if (rx_read) ackd = 1'b1;
      if (ackd) begin
         if ($urandom_range(0, 1) == 1) begin
            rda  = 1'b0;
            ackd = 1'b0;
            gap  = int'($urandom_range(0, 2));
         end
      end else if (!rda) begin
         if (gap > 0) gap--;
         else if (int'($urandom_range(0, 99)) < p_push) begin
            rda     = 1'b1;
            rx_data = WIDTH'($urandom);
         end
      end
      rd_en   = int'($urandom_range(0, 99)) < p_pop;
      clr_ovr = $urandom_range(0, 99) < 5;
   endtask

   int push_tab[5] = '{90, 50, 20, 90, 60};
   int pop_tab[5]  = '{5, 50, 90, 90, 30};

   initial begin
      bit seen;
      model_reset();
      #12;
      check_outputs();
      rst_n = 1'b1;

      for (int ph = 0; ph < 5; ph++) begin
         p_push = push_tab[ph];
         p_pop  = pop_tab[ph];
         for (int c = 0; c < 300; c++) begin
            cycle();
            drive();
         end
      end

      // Reset while the acknowledge pulse is on the wire.
      p_push = 100;
      p_pop  = 50;
      seen   = 1'b0;
      for (int c = 0; c < 200; c++) begin
         cycle();
         if (rx_read) begin
            seen = 1'b1;
            break;
         end
         drive();
      end
      check("ack_seen", 32'(seen), 32'd1);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      rda   = 1'b0;
      ackd  = 1'b0;
      gap   = 0;
      rd_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      p_push = 70;
      p_pop  = 40;
      for (int c = 0; c < 300; c++) begin
         cycle();
         drive();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
